// File: rtl/rx_frame_sequencer.sv
// Receive frame sequencer: sync search, SIGNAL check, DATA/flush gating.
// Optional: define RX_TAIL_CHECK_EN to reject SIGNAL fields with nonzero tail bits.
module rx_frame_sequencer #(
  parameter int unsigned PREAMBLE_LEN = 12,
  parameter int unsigned MAX_LEN      = 4095,
  parameter int unsigned FLUSH_CYCLES = 36
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        Data,
  input  logic        Data_valid,
  output logic        Dec_En,
  output logic        Dec_Last,
  output logic [3:0]  Rate,
  output logic [11:0] Length,
  output logic        Sig_valid,
  output logic        Sig_err,
  output logic        Frame_done,
  output logic        Busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_SIG   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;

  localparam logic [7:0] PL = 8'(PREAMBLE_LEN);
  localparam logic [7:0] FL = 8'(FLUSH_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  sig_cnt_q, sig_cnt_d;
  logic [23:0] sig_q, sig_d;
  logic [3:0]  rate_q, rate_d;
  logic [11:0] len_q, len_d;
  logic [7:0]  ndbps_q, ndbps_d;
  logic [15:0] need_q, need_d;
  logic [15:0] acc_q, acc_d;
  logic [8:0]  cb_q, cb_d;
  logic [7:0]  fl_cnt_q, fl_cnt_d;
  logic        data_q, data_d;
  logic        flush_q, flush_d;

  logic [3:0]  sig_rate;
  logic [11:0] sig_len;
  logic [7:0]  sig_ndbps;
  logic        chk_err;
  logic        in_check;
  logic [8:0]  two_n;
  logic        sym_end;
  logic [15:0] acc_nx;
  logic        done_ok;
  logic        fl_end;

  // Rate is held with R1 in bit 0; 0 marks an unsupported code.
  function automatic logic [7:0] ndbps_of(input logic [3:0] r);
    logic [7:0] n;
    n = 8'd0;
    case (r)
      4'b1011: n = 8'd24;
      4'b1111: n = 8'd36;
      4'b1010: n = 8'd48;
      4'b1110: n = 8'd72;
      4'b1001: n = 8'd96;
      4'b1101: n = 8'd144;
      4'b1000: n = 8'd192;
      4'b1100: n = 8'd216;
      default: n = 8'd0;
    endcase
    return n;
  endfunction

  assign sig_rate  = sig_q[3:0];
  assign sig_len   = sig_q[16:5];
  assign sig_ndbps = ndbps_of(sig_rate);

  always_comb begin
    chk_err = (^sig_q[17:0])
            | sig_q[4]
            | (sig_ndbps == 8'd0)
            | (sig_len == 12'd0)
            | ({20'd0, sig_len} > MAX_LEN);
`ifdef RX_TAIL_CHECK_EN
    chk_err = chk_err | (|sig_q[23:18]);
`else
    chk_err = chk_err;
`endif
  end

  assign in_check = (state_q == S_CHECK);
  assign two_n    = {ndbps_q, 1'b0};
  assign sym_end  = (cb_q == (two_n - 9'd1));
  assign acc_nx   = acc_q + {8'd0, ndbps_q};
  assign done_ok  = data_q & Data_valid & sym_end & (acc_nx >= need_q);
  assign fl_end   = flush_q & (fl_cnt_q == (FL - 8'd1));

  assign Dec_En     = (data_q & Data_valid) | flush_q;
  assign Dec_Last   = done_ok;
  assign Rate       = rate_q;
  assign Length     = len_q;
  assign Sig_valid  = in_check & ~chk_err;
  assign Sig_err    = in_check & chk_err;
  assign Frame_done = fl_end;
  assign Busy       = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    sig_cnt_d = sig_cnt_q;
    sig_d     = sig_q;
    rate_d    = rate_q;
    len_d     = len_q;
    ndbps_d   = ndbps_q;
    need_d    = need_q;
    acc_d     = acc_q;
    cb_d      = cb_q;
    fl_cnt_d  = fl_cnt_q;
    data_d    = data_q;
    flush_d   = flush_q;
    unique case (state_q)
      S_IDLE: begin
        if (Data_valid && Data) begin
          if (PL <= 8'd1) begin
            state_d   = S_SIG;
            sig_cnt_d = 5'd0;
          end else begin
            state_d   = S_PRE;
            pre_cnt_d = 8'd1;
          end
        end
      end
      S_PRE: begin
        if (Data_valid) begin
          if (!Data) begin
            state_d   = S_IDLE;
            pre_cnt_d = 8'd0;
          end else if (pre_cnt_q + 8'd1 >= PL) begin
            state_d   = S_SIG;
            pre_cnt_d = 8'd0;
            sig_cnt_d = 5'd0;
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end
      end
      S_SIG: begin
        if (Data_valid) begin
          sig_d = {Data, sig_q[23:1]};
          if (sig_cnt_q == 5'd23) begin
            state_d   = S_CHECK;
            sig_cnt_d = 5'd0;
          end else begin
            sig_cnt_d = sig_cnt_q + 5'd1;
          end
        end
      end
      S_CHECK: begin
        if (chk_err) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          rate_d  = sig_rate;
          len_d   = sig_len;
          ndbps_d = sig_ndbps;
          // 16 SERVICE + 6 tail bits ahead of/behind the payload octets.
          need_d  = 16'd22 + {1'b0, sig_len, 3'b000};
          acc_d   = 16'd0;
          cb_d    = 9'd0;
          data_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (Data_valid) begin
          if (sym_end) begin
            cb_d = 9'd0;
            if (acc_nx >= need_q) begin
              state_d  = S_FLUSH;
              data_d   = 1'b0;
              flush_d  = 1'b1;
              fl_cnt_d = 8'd0;
              acc_d    = 16'd0;
            end else begin
              acc_d = acc_nx;
            end
          end else begin
            cb_d = cb_q + 9'd1;
          end
        end
      end
      S_FLUSH: begin
        if (fl_end) begin
          state_d  = S_IDLE;
          flush_d  = 1'b0;
          fl_cnt_d = 8'd0;
        end else begin
          fl_cnt_d = fl_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        data_d  = 1'b0;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset || !En) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      sig_cnt_q <= '0;
      sig_q     <= '0;
      rate_q    <= '0;
      len_q     <= '0;
      ndbps_q   <= '0;
      need_q    <= '0;
      acc_q     <= '0;
      cb_q      <= '0;
      fl_cnt_q  <= '0;
      data_q    <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      sig_cnt_q <= sig_cnt_d;
      sig_q     <= sig_d;
      rate_q    <= rate_d;
      len_q     <= len_d;
      ndbps_q   <= ndbps_d;
      need_q    <= need_d;
      acc_q     <= acc_d;
      cb_q      <= cb_d;
      fl_cnt_q  <= fl_cnt_d;
      data_q    <= data_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Scoreboard bench for rx_frame_sequencer with a frame-level reference model.
// Stimulus pushes expected SIGNAL outcomes; a negedge monitor checks them.
module tb_rx_frame_sequencer;

  localparam int FLUSH = 36;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        En = 1'b1;
  logic        Data = 1'b0;
  logic        Data_valid = 1'b0;
  logic        Dec_En, Dec_Last, Sig_valid, Sig_err, Frame_done, Busy;
  logic [3:0]  Rate;
  logic [11:0] Length;

  rx_frame_sequencer dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Data(Data),
    .Data_valid(Data_valid), .Dec_En(Dec_En), .Dec_Last(Dec_Last),
    .Rate(Rate), .Length(Length), .Sig_valid(Sig_valid),
    .Sig_err(Sig_err), .Frame_done(Frame_done), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit       err;
    bit [3:0] rate_o;
    int       len;
    int       coded;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;
  int exp_done = 0;
  int got_done = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: data bits per OFDM symbol, keyed by R1..R4 in transmit order.
  function automatic int ndbps_ref(input bit [3:0] code);
    case (code)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input logic d, input logic v);
    @(posedge Clk);
    #1;
    Data = d;
    Data_valid = v;
  endtask

  // vmode: 0 always valid, 1 alternate valid/invalid, 2 random gaps
  task automatic vbit(input logic d, input int vmode);
    if (vmode == 2) begin
      while ($urandom_range(0, 3) == 0) drive(1'($urandom), 1'b0);
    end
    drive(d, 1'b1);
    if (vmode == 1) drive(1'($urandom), 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy !== 1'b0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("idle_timeout", longint'(n >= 200), 0);
  endtask

  // abort_kind: 0 none, 1 Reset, 2 En
  task automatic frame(input bit [3:0] code, input int len, input bit flip,
                       input bit resv, input bit [5:0] tail, input int vmode,
                       input int abort_at, input int abort_kind,
                       input bit bad_pre);
    bit   sb[24];
    bit   par;
    exp_t e;
    int   nd, need, nsym;
    bit   tail_bad;
    par = 0;
    for (int i = 0; i < 4; i++) sb[i] = code[3-i];
    sb[4] = resv;
    for (int j = 0; j < 12; j++) sb[5+j] = len[j];
    for (int i = 0; i < 17; i++) par ^= sb[i];
    sb[17] = par ^ flip;
    for (int k = 0; k < 6; k++) sb[18+k] = tail[k];
`ifdef RX_TAIL_CHECK_EN
    tail_bad = (tail != 6'd0);
`else
    tail_bad = 1'b0;
`endif
    nd = ndbps_ref(code);
    e.err = flip | resv | (nd == 0) | (len == 0) | (len > 4095) | tail_bad;
    e.rate_o = {code[0], code[1], code[2], code[3]};
    e.len = len;
    need = 22 + 8 * len;
    nsym = (nd == 0) ? 0 : (need + nd - 1) / nd;
    e.coded = 2 * nd * nsym;
    expq.push_back(e);
    if (bad_pre) begin
      for (int i = 0; i < 10; i++) vbit(1'b1, vmode);
      vbit(1'b0, vmode);
    end
    for (int i = 0; i < 12; i++) vbit(1'b1, vmode);
    for (int i = 0; i < 24; i++) vbit(sb[i], vmode == 1 ? 0 : vmode);
    drive(1'b0, 1'b0);
    if (e.err) begin
      drive(1'b0, 1'b0);
      @(negedge Clk);
      chk("busy_after_err", Busy, 0);
      return;
    end
    for (int i = 0; i < e.coded; i++) begin
      if (abort_kind != 0 && i == abort_at) begin
        @(posedge Clk);
        #1;
        Data_valid = 1'b0;
        if (abort_kind == 1) Reset = 1'b0;
        else En = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("abort_outs", {Dec_En, Dec_Last, Rate, Length, Sig_valid,
                           Sig_err, Frame_done, Busy}, 0);
        #1;
        Reset = 1'b1;
        En = 1'b1;
        return;
      end
      vbit(1'($urandom), vmode);
    end
    exp_done++;
    for (int i = 0; i < FLUSH + 4; i++) drive(1'b0, 1'($urandom));
    wait_idle();
  endtask

  // Monitor: frame-level scoreboard.
  bit   infr = 0, flsh = 0;
  int   dcnt = 0, fcnt = 0;
  exp_t cur;

  always @(negedge Clk) begin
    if (!Reset || !En) begin
      infr = 0;
      flsh = 0;
    end else begin
      if (Sig_valid && Sig_err) chk("sig_both", 1, 0);
      if (Sig_valid || Sig_err) begin
        if (expq.size() == 0) begin
          chk("sig_unexpected", 1, 0);
        end else begin
          cur = expq.pop_front();
          chk("sig_err_kind", Sig_err, cur.err);
          if (Sig_valid && !cur.err) begin
            infr = 1;
            dcnt = 0;
          end
        end
      end else if (infr) begin
        chk("dec_en_gate", Dec_En, Data_valid);
        if (Dec_En && Data_valid) dcnt++;
        if (Dec_Last) begin
          chk("coded_bits", dcnt, cur.coded);
          chk("rate_out", Rate, cur.rate_o);
          chk("length_out", Length, cur.len);
          infr = 0;
          flsh = 1;
          fcnt = 0;
        end
      end else if (flsh) begin
        if (Dec_En) fcnt++;
        if (Frame_done) begin
          chk("flush_len", fcnt, FLUSH);
          flsh = 0;
          got_done++;
        end
      end else if (Dec_En || Dec_Last || Frame_done) begin
        chk("stray_output", {Dec_En, Dec_Last, Frame_done}, 0);
      end
    end
  end

  bit [3:0] codes[8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                         4'b1001, 4'b1011, 4'b0001, 4'b0011};

  initial begin
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outs", {Dec_En, Dec_Last, Rate, Length, Sig_valid,
                       Sig_err, Frame_done, Busy}, 0);
    #1;
    Reset = 1'b1;
    drive(1'b0, 1'b0);
    frame(4'b1101, 1, 0, 0, 6'd0, 0, 0, 0, 0);
    frame(4'b0011, 100, 0, 0, 6'd0, 0, 0, 0, 0);
    frame(4'b1101, 5, 0, 0, 6'd0, 0, 0, 0, 1);
    frame(4'b1101, 1, 1, 0, 6'd0, 0, 0, 0, 0);
    frame(4'b1101, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    frame(4'b0000, 1, 0, 0, 6'd0, 0, 0, 0, 0);
    frame(4'b1001, 3, 0, 1, 6'd0, 0, 0, 0, 0);
    frame(4'b1101, 1, 0, 0, 6'd0, 1, 0, 0, 0);
    frame(4'b1101, 1, 0, 0, 6'd0, 0, 50, 1, 0);
    drive(1'b0, 1'b0);
    frame(4'b1101, 1, 0, 0, 6'd0, 0, 0, 0, 0);
    frame(4'b0111, 7, 0, 0, 6'b000100, 0, 0, 0, 0);
    frame(4'b1111, 9, 0, 0, 6'd0, 2, 20, 2, 0);
    drive(1'b0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      bit [3:0] c;
      c = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) c = 4'($urandom);
      frame(c, $urandom_range(1, 40), ($urandom_range(0, 7) == 0), 0,
            6'd0, $urandom_range(0, 2), 0, 0, 0);
    end
    repeat (5) drive(1'b0, 1'b0);
    @(negedge Clk);
    chk("queue_empty", expq.size(), 0);
    chk("frames_done", got_done, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
